// File: rtl/pc_sequencer.sv
// Next-PC select and hold for the MIPS pipeline: redirects act on pc_next the same cycle.
// On an exception the PC is frozen for DRAIN_CYCLES cycles, then loads EXC_VECTOR.
module pc_sequencer #(
  parameter logic [31:0] EXC_VECTOR   = 32'h00400004,
  parameter int          DRAIN_CYCLES = 3,
  parameter int          MAX_STALL    = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_current,
  input  logic        imem_ready,
  input  logic        stall_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc_req,
  input  logic        eret,
  output logic        pc_enable,
  output logic [31:0] pc_next,
  output logic        flush_if_id,
  output logic        in_exception,
  output logic [31:0] epc_out,
  output logic        stall_timeout
);

  typedef enum logic [1:0] {RUN, STALL, DRAIN, VECTOR} state_t;

  localparam logic [3:0] DRAIN_INIT  = 4'(DRAIN_CYCLES - 1);
  localparam logic [7:0] STALL_LIMIT = 8'(MAX_STALL);

  state_t      state, state_d;
  logic [3:0]  drain_cnt, drain_cnt_d;
  logic [7:0]  stall_cnt, stall_cnt_d;
  logic [31:0] epc_d;
  logic [31:0] pc_inc;
  logic        en, flush;

  assign pc_inc = pc_current + 32'd4;

  always_comb begin
    state_d      = state;
    drain_cnt_d  = drain_cnt;
    stall_cnt_d  = stall_cnt;
    epc_d        = epc_out;
    en           = 1'b0;
    flush        = 1'b0;
    pc_next      = pc_inc;
    in_exception = 1'b0;
    case (state)
      RUN: begin
        if (exc_req) begin
          flush       = 1'b1;
          epc_d       = pc_current;
          drain_cnt_d = DRAIN_INIT;
          state_d     = DRAIN;
        end else if (eret) begin
          en      = 1'b1;
          pc_next = epc_out;
          flush   = 1'b1;
        end else if (branch_taken) begin
          en      = 1'b1;
          pc_next = branch_target;
          flush   = 1'b1;
        end else if (jump) begin
          en      = 1'b1;
          pc_next = jump_target;
          flush   = 1'b1;
        end else if (stall_req) begin
          stall_cnt_d = 8'd1;
          state_d     = STALL;
        end else begin
          en = imem_ready;
        end
      end
      STALL: begin
        // redirects are ignored here; only an exception can leave a stall early
        if (exc_req) begin
          flush       = 1'b1;
          epc_d       = pc_current;
          drain_cnt_d = DRAIN_INIT;
          stall_cnt_d = 8'd0;
          state_d     = DRAIN;
        end else if (stall_req) begin
          stall_cnt_d = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;
        end else begin
          en          = imem_ready;
          stall_cnt_d = 8'd0;
          state_d     = RUN;
        end
      end
      DRAIN: begin
        flush        = 1'b1;
        in_exception = 1'b1;
        if (drain_cnt == 4'd0) state_d = VECTOR;
        else                   drain_cnt_d = drain_cnt - 4'd1;
      end
      VECTOR: begin
        en      = 1'b1;
        pc_next = EXC_VECTOR;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign pc_enable   = en & ~reset;
  assign flush_if_id = flush & ~reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      drain_cnt     <= 4'd0;
      stall_cnt     <= 8'd0;
      epc_out       <= 32'd0;
      stall_timeout <= 1'b0;
    end else begin
      state     <= state_d;
      drain_cnt <= drain_cnt_d;
      stall_cnt <= stall_cnt_d;
      epc_out   <= epc_d;
      // counter only moves by one, so equality catches the crossing
      if (stall_cnt_d == STALL_LIMIT) stall_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_pc_sequencer;

  localparam logic [31:0] EXCV = 32'h00400004;
  localparam int DC = 3;
  localparam int MS = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_current = 32'd0;
  logic        imem_ready = 1'b0, stall_req = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic        exc_req = 1'b0, eret = 1'b0;
  logic [31:0] branch_target = 32'd0, jump_target = 32'd0;
  logic        pc_enable, flush_if_id, in_exception, stall_timeout;
  logic [31:0] pc_next, epc_out;

  pc_sequencer #(.EXC_VECTOR(EXCV), .DRAIN_CYCLES(DC), .MAX_STALL(MS)) dut (
    .clock(clock), .reset(reset), .pc_current(pc_current), .imem_ready(imem_ready),
    .stall_req(stall_req), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exc_req(exc_req), .eret(eret),
    .pc_enable(pc_enable), .pc_next(pc_next), .flush_if_id(flush_if_id),
    .in_exception(in_exception), .epc_out(epc_out), .stall_timeout(stall_timeout)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: drain cycles still to go, a pending vector cycle, stall run length
  int          m_drain = 0;
  bit          m_vec = 0, m_stall = 0, m_to = 0;
  int          m_scnt = 0;
  logic [31:0] m_epc = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_drain = 0; m_vec = 0; m_stall = 0; m_to = 0; m_scnt = 0; m_epc = 32'd0;
  endtask

  task automatic step(input logic [31:0] pc, input logic ir, input logic sr,
                      input logic bt, input logic [31:0] btg,
                      input logic jp, input logic [31:0] jt,
                      input logic ex, input logic er);
    int nd, nsc;
    bit nv, ns, nto;
    logic [31:0] nepc, e_nx;
    logic e_en, e_fl, e_ie;
    @(negedge clock);
    pc_current = pc; imem_ready = ir; stall_req = sr; branch_taken = bt;
    branch_target = btg; jump = jp; jump_target = jt; exc_req = ex; eret = er;
    nd = m_drain; nv = 0; ns = m_stall; nsc = m_scnt; nepc = m_epc; nto = m_to;
    e_en = 0; e_fl = 0; e_ie = 0; e_nx = pc + 32'd4;
    if (m_drain > 0) begin
      e_fl = 1; e_ie = 1; nd = m_drain - 1; nv = (nd == 0);
    end else if (m_vec) begin
      e_en = 1; e_nx = EXCV;
    end else if (ex) begin
      e_fl = 1; nepc = pc; nd = DC; ns = 0; nsc = 0;
    end else if (m_stall) begin
      if (sr) nsc = (m_scnt < 255) ? m_scnt + 1 : 255;
      else begin e_en = ir; ns = 0; nsc = 0; end
    end else if (er) begin
      e_en = 1; e_fl = 1; e_nx = m_epc;
    end else if (bt) begin
      e_en = 1; e_fl = 1; e_nx = btg;
    end else if (jp) begin
      e_en = 1; e_fl = 1; e_nx = jt;
    end else if (sr) begin
      ns = 1; nsc = 1;
    end else begin
      e_en = ir;
    end
    if (nsc == MS) nto = 1;
    #1;
    check("pc_enable", pc_enable, e_en);
    check("pc_next", pc_next, e_nx);
    check("flush_if_id", flush_if_id, e_fl);
    check("in_exception", in_exception, e_ie);
    check("epc_out", epc_out, m_epc);
    check("stall_timeout", stall_timeout, m_to);
    @(posedge clock);
    m_drain = nd; m_vec = nv; m_stall = ns; m_scnt = nsc; m_epc = nepc; m_to = nto;
  endtask

  task automatic idle(input logic [31:0] pc);
    step(pc, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_steps(input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      step(pc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom & 32'hFFFFFFFC,
           $urandom_range(0, 7) == 0, $urandom & 32'hFFFFFFFC,
           $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
    end
  endtask

  initial begin
    #2;
    check("rst_pc_enable", pc_enable, 0);
    check("rst_flush", flush_if_id, 0);
    check("rst_in_exception", in_exception, 0);
    check("rst_epc", epc_out, 0);
    check("rst_timeout", stall_timeout, 0);
    @(negedge clock); reset = 1'b0;
    model_reset();

    idle(32'h00400000);
    step(32'h00400010, 1, 0, 1, 32'h00400100, 0, 0, 0, 0);
    step(32'h00400014, 1, 0, 0, 0, 1, 32'h00400200, 0, 0);
    for (int i = 0; i < 3; i++) step(32'h00400020, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(32'h00400020);
    step(32'h00400024, 0, 0, 0, 0, 0, 0, 0, 0);
    // exception with a coincident branch; a second exception arrives mid-drain
    step(32'h00400040, 1, 0, 1, 32'h00400300, 0, 0, 1, 0);
    step(32'h00400044, 1, 0, 0, 0, 0, 0, 1, 0);
    idle(32'h00400044);
    idle(32'h00400044);
    step(32'h00400044, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(EXCV);
    step(EXCV, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(32'hFFFFFFFC);
    // branch/jump/eret during a stall must be ignored
    step(32'h00400080, 1, 1, 0, 0, 0, 0, 0, 0);
    step(32'h00400080, 1, 1, 1, 32'h00400500, 1, 32'h00400600, 0, 1);
    for (int i = 0; i < 13; i++) step(32'h00400080, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(32'h00400080);
    idle(32'h00400084);
    rand_steps(400);

    // reset in the second drain cycle aborts without a vector cycle
    step(32'h00400100, 1, 0, 0, 0, 0, 0, 1, 0);
    step(32'h00400100, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); reset = 1'b1;
    #1;
    check("abort_in_exception", in_exception, 0);
    check("abort_epc", epc_out, 0);
    check("abort_pc_enable", pc_enable, 0);
    check("abort_flush", flush_if_id, 0);
    check("abort_timeout", stall_timeout, 0);
    model_reset();
    @(negedge clock); reset = 1'b0;
    idle(32'h00400200);
    idle(32'hFFFFFFFC);
    rand_steps(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
